rf_scan_reader: RTL and testbench
=================================

Name: rf_scan_reader

Overview:
- Read-side companion to the register file's write/record path.
- On a start pulse it walks an inclusive register address range through read port 1 of the register file.
- It accounts for the file's one-cycle registered read and for read inhibit while the file is writing or recording.
- Each (address, data) pair is presented to a downstream consumer (LED/seven-segment display logic) over a valid/ready handshake.

Parameters:
- AW, 3, register address width (8 registers)
- DW, 4, register data width

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- start  input  1  one-cycle pulse; begins a scan when idle, ignored when busy
- first_addr  input  AW  first address of scan, sampled on accepted start
- last_addr  input  AW  last address of scan (inclusive), sampled on accepted start
- RF_ad1  output  AW  read address driven to register file read port 1
- RF_d1  input  DW  registered read data from register file port 1
- rf_inhibit  input  1  high when the register file will not update RF_d1 this cycle (RF_we OR record)
- out_valid  output  1  out_addr/out_data hold a scanned pair
- out_ready  input  1  consumer accepts the pair when out_valid AND out_ready
- out_addr  output  AW  address of presented pair
- out_data  output  DW  data of presented pair
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last pair is accepted

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-scan:
  - state goes to IDLE.
  - RF_ad1, out_addr, out_data, cur_addr and end_addr go to 0.
  - out_valid, busy and done go to 0.
- State machine, states IDLE, ISSUE, CAPTURE, PRESENT, DONE:
  - IDLE: start=1 loads cur_addr=first_addr and end_addr=last_addr, then goes to ISSUE.
  - ISSUE: RF_ad1=cur_addr.
    - If rf_inhibit=0 at the edge, go to CAPTURE; the register file loads RF_d1 on this same edge.
    - If rf_inhibit=1, stay in ISSUE and keep RF_ad1 stable.
  - CAPTURE: latch out_data<=RF_d1 and out_addr<=cur_addr, set out_valid<=1, go to PRESENT. rf_inhibit is ignored here because RF_d1 is already loaded.
  - PRESENT: out_valid=1; out_addr and out_data are held stable until the handshake.
    - On handshake, clear out_valid at the edge.
    - If cur_addr==end_addr, go to DONE.
    - Otherwise cur_addr<=cur_addr+1 (mod 2^AW) and go to ISSUE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- RF_ad1 in IDLE holds its last value; its value there is don't-care to the file.
- Range and wrap-around:
  - The address increment wraps 7->0.
  - If last_addr<first_addr, the scan wraps. Example: 6,7,0,1.
  - If first_addr==last_addr, exactly one pair is produced.
  - Maximum scan length is 2^AW pairs.
- Latency: start edge to out_valid=1 is 3 clocks with no inhibit and ready held high. Each following pair is also 3 clocks (PRESENT -> ISSUE -> CAPTURE -> PRESENT).
- Backpressure: out_ready low holds PRESENT indefinitely with no change to outputs.
- Simultaneous events:
  - start while busy is ignored, with no effect on the range.
  - A write to the scanned register during CAPTURE or PRESENT does not change out_data; the snapshot is the pre-write value.
  - A write landing before ISSUE completes is seen.
- done and out_valid are never high in the same cycle.

Decomposition:
- Shared package rf_pkg:
  - constants RF_AW=3 and RF_DW=4.
  - typedef rf_addr_t = logic[RF_AW-1:0] and rf_data_t = logic[RF_DW-1:0].
  - enum scan_state_t {IDLE, ISSUE, CAPTURE, PRESENT, DONE}.
- Single module. The address sequencer (cur_addr, end_addr, last-compare) is small enough to stay inline; no sub-module.

Test Plan:
- Register file freshly reset (contents 6,3,2,3,4,5,6,7), start with first=0/last=7, out_ready=1 -> 8 pairs (0,6)(1,3)(2,2)(3,3)(4,4)(5,5)(6,6)(7,7), first out_valid 3 clocks after start, done pulse once, busy low after.
- first=6, last=1 -> pairs (6,6)(7,7)(0,6)(1,3) in that order, then done.
- first=last=2, out_ready held low 5 cycles after out_valid -> (2,2) held stable 5 cycles, accepted on ready, done next cycle.
- rf_inhibit=1 for 4 cycles during ISSUE at addr 3 while a record writes 9 to reg 3 -> RF_ad1 stays 3, pair (3,9) presented after inhibit drops.
- start pulsed again mid-scan with first=5 -> ignored, original sequence unchanged; rst=1 while in PRESENT -> next cycle out_valid=0, busy=0, IDLE; a fresh start scans normally.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions.
//
// Holds the register-file geometry, the address/data types and the state
// encoding of the scan reader. Every rf_* module imports this package so
// that width changes happen in one place.
package rf_pkg;

  localparam int RF_AW = 3;  // 8 registers
  localparam int RF_DW = 4;  // 4-bit register contents

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    PRESENT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/rf_scan_reader.sv
// rf_scan_reader
//
// Walks an inclusive register address range through read port 1 of the
// register file. Each (address, data) pair is handed to a downstream consumer
// over a valid/ready handshake. Ranges with last < first wrap through
// address 0.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse, begins a scan when idle (ignored when busy)
//   first_addr  first address of the scan, sampled on an accepted start
//   last_addr   last address of the scan (inclusive), sampled on start
//   RF_ad1      read address to register file port 1
//   RF_d1       registered read data from register file port 1
//   rf_inhibit  register file will not update RF_d1 this cycle
//   out_valid   out_addr/out_data hold a scanned pair
//   out_ready   consumer accepts the pair when out_valid is also high
//   out_addr    address of the presented pair
//   out_data    data of the presented pair
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last pair has been accepted
module rf_scan_reader
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] RF_ad1,
  input  logic [DW-1:0] RF_d1,
  input  logic          rf_inhibit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  scan_state_t   state_reg, state_next;
  logic [AW-1:0] cur_addr_reg, cur_addr_next;
  logic [AW-1:0] end_addr_reg, end_addr_next;
  logic [AW-1:0] ad1_reg, ad1_next;
  logic [AW-1:0] out_addr_reg, out_addr_next;
  logic [DW-1:0] out_data_reg, out_data_next;
  logic          out_valid_reg, out_valid_next;

  // Natural AW-bit overflow gives the 2^AW-1 -> 0 wrap for free.
  logic [AW-1:0] addr_inc;
  assign addr_inc = cur_addr_reg + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      end_addr_reg  <= '0;
      ad1_reg       <= '0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      end_addr_reg  <= end_addr_next;
      ad1_reg       <= ad1_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    end_addr_next  = end_addr_reg;
    ad1_next       = ad1_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cur_addr_next = first_addr;
          end_addr_next = last_addr;
          // Read address is loaded together with cur_addr so it is already
          // valid for the whole ISSUE cycle.
          ad1_next      = first_addr;
          state_next    = ISSUE;
        end
      end

      ISSUE: begin
        // The file loads RF_d1 on the same edge that inhibit is low, so
        // leaving ISSUE here means the read has been performed.
        if (!rf_inhibit) begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        // Snapshot now: later writes to this register must not leak into
        // the presented pair.
        out_data_next  = RF_d1;
        out_addr_next  = cur_addr_reg;
        out_valid_next = 1'b1;
        state_next     = PRESENT;
      end

      PRESENT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          if (cur_addr_reg == end_addr_reg) begin
            state_next = DONE;
          end else begin
            cur_addr_next = addr_inc;
            ad1_next      = addr_inc;
            state_next    = ISSUE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign RF_ad1    = ad1_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);
  // out_valid is cleared on the edge entering DONE, so the two never overlap.
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_rf_scan_reader.sv
// Testbench for rf_scan_reader: a small register file model drives RF_d1,
// expected pairs come from a shadow copy of the register contents and the
// scan range (addresses first, first+1, ... mod 8 up to last).
module tb_rf_scan_reader;
  import rf_pkg::*;

  logic           clk;
  logic           rst;
  logic           start;
  logic [RF_AW-1:0] first_addr;
  logic [RF_AW-1:0] last_addr;
  logic [RF_AW-1:0] RF_ad1;
  logic [RF_DW-1:0] RF_d1;
  logic           rf_inhibit;
  logic           out_valid;
  logic           out_ready;
  logic [RF_AW-1:0] out_addr;
  logic [RF_DW-1:0] out_data;
  logic           busy;
  logic           done;

  rf_scan_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .RF_ad1     (RF_ad1),
    .RF_d1      (RF_d1),
    .rf_inhibit (rf_inhibit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  int pair_cnt = 0;
  int exp_a[$];
  int exp_d[$];
  int ref_mem[8];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int init_val(input int i);
    int v;
    v = (i == 0) ? 6 : (i == 2) ? 2 : (i == 1 || i == 3) ? 3 : i;
    return v;
  endfunction

  // ---------------- register file model ----------------
  logic             rf_rst;
  logic             rf_we;
  logic [RF_AW-1:0] rf_wa;
  logic [RF_DW-1:0] rf_wd;
  logic [RF_DW-1:0] rf_mem [8];
  logic             man_rec, rnd_inh, man_ready, rnd_ready;
  int               inh_mode, rdy_mode;

  assign rf_inhibit = rf_we | ((inh_mode != 0) ? rnd_inh : man_rec);
  assign out_ready  = (rdy_mode != 0) ? rnd_ready : man_ready;

  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= RF_DW'(init_val(i));
      RF_d1 <= '0;
    end else begin
      if (rf_we) rf_mem[rf_wa] <= rf_wd;
      if (!rf_inhibit) RF_d1 <= rf_mem[RF_ad1];
    end
  end

  initial begin
    rnd_ready = 1'b1;
    rnd_inh   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
      rnd_inh   = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic hold_prev;
    int   prev_a, prev_d, ea, ed;
    hold_prev = 1'b0;
    prev_a = 0;
    prev_d = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          check("done_vs_valid", int'(out_valid), 0);
        end
        if (hold_prev) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_addr", int'(out_addr), prev_a);
          check("hold_data", int'(out_data), prev_d);
        end
        if (out_valid && out_ready) begin
          pair_cnt++;
          $display("pair addr=%0d data=%0d", out_addr, out_data);
          if (exp_a.size() == 0) begin
            check("unexpected_pair", 1, 0);
          end else begin
            ea = exp_a.pop_front();
            ed = exp_d.pop_front();
            check("pair_addr", int'(out_addr), ea);
            check("pair_data", int'(out_data), ed);
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_a = int'(out_addr);
        prev_d = int'(out_data);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  function automatic int scan_len(input int f, input int l);
    return ((l - f) & 7) + 1;
  endfunction

  task automatic push_range(input int f, input int l);
    int a;
    for (int i = 0; i < scan_len(f, l); i++) begin
      a = (f + i) % 8;
      exp_a.push_back(a);
      exp_d.push_back(ref_mem[a]);
    end
  endtask

  task automatic do_start(input int f, input int l);
    first_addr = RF_AW'(f);
    last_addr  = RF_AW'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("timeout_valid", 0, 1);
  endtask

  // Waits for the done pulse, then checks it lasted one cycle and busy fell.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      check("timeout_done", 0, 1);
    end else begin
      @(posedge clk);
      #1;
      check("done_width", int'(done), 0);
      check("busy_after", int'(busy), 0);
    end
  endtask

  task automatic run_scan(input int f, input int l);
    int d0, p0;
    d0 = done_cnt;
    p0 = pair_cnt;
    push_range(f, l);
    do_start(f, l);
    wait_done(3000);
    check("scan_left", exp_a.size(), 0);
    check("scan_pairs", pair_cnt - p0, scan_len(f, l));
    check("scan_dones", done_cnt - d0, 1);
  endtask

  task automatic rf_write(input int a, input int d);
    rf_we = 1'b1;
    rf_wa = RF_AW'(a);
    rf_wd = RF_DW'(d);
    @(posedge clk);
    #1;
    rf_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, d0, p0, f, l;
    rst = 1'b1;
    rf_rst = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    man_rec = 1'b0;
    man_ready = 1'b1;
    inh_mode = 0;
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rf_rst = 1'b0;

    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ad1", int'(RF_ad1), 0);
    check("rst_oaddr", int'(out_addr), 0);
    check("rst_odata", int'(out_data), 0);

    // Full scan 0..7 with latency measurement.
    d0 = done_cnt;
    p0 = pair_cnt;
    push_range(0, 7);
    do_start(0, 7);
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_latency", n, 3);
    wait_done(200);
    check("full_left", exp_a.size(), 0);
    check("full_pairs", pair_cnt - p0, 8);
    check("full_dones", done_cnt - d0, 1);

    // Wrapping range 6 -> 1.
    run_scan(6, 1);

    // Single register with backpressure.
    man_ready = 1'b0;
    push_range(2, 2);
    do_start(2, 2);
    wait_valid(20);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_addr", int'(out_addr), 2);
      check("bp_data", int'(out_data), 2);
    end
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done", int'(done), 1);
    check("bp_valid_clr", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("bp_done_end", int'(done), 0);
    check("bp_busy_end", int'(busy), 0);

    // Inhibit for 4 cycles in ISSUE while a record writes 9 to reg 3.
    exp_a.push_back(3);
    exp_d.push_back(9);
    do_start(3, 3);
    rf_we = 1'b1;
    rf_wa = 3'd3;
    rf_wd = 4'd9;
    man_rec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("inh_ad1", int'(RF_ad1), 3);
      check("inh_no_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      rf_we = 1'b0;
    end
    man_rec = 1'b0;
    ref_mem[3] = 9;
    wait_done(50);
    check("inh_left", exp_a.size(), 0);

    // Start pulsed while busy must be ignored.
    d0 = done_cnt;
    p0 = pair_cnt;
    push_range(0, 7);
    do_start(0, 7);
    repeat (4) @(posedge clk);
    #1;
    do_start(5, 5);
    wait_done(200);
    check("ign_left", exp_a.size(), 0);
    check("ign_pairs", pair_cnt - p0, 8);
    check("ign_dones", done_cnt - d0, 1);

    // Reset while in PRESENT.
    man_ready = 1'b0;
    push_range(0, 2);
    do_start(0, 2);
    wait_valid(20);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_a.delete();
    exp_d.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ad1", int'(RF_ad1), 0);
    check("mid_rst_oaddr", int'(out_addr), 0);
    check("mid_rst_odata", int'(out_data), 0);
    man_ready = 1'b1;
    run_scan(1, 3);

    // Randomized scans with random backpressure and inhibit.
    for (int k = 0; k < 20; k++) begin
      inh_mode = 0;
      rdy_mode = 0;
      rf_write($urandom_range(0, 7), $urandom_range(0, 15));
      f = $urandom_range(0, 7);
      l = $urandom_range(0, 7);
      inh_mode = 1;
      rdy_mode = 1;
      run_scan(f, l);
    end
    inh_mode = 0;
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
